// File: rtl/wb_pkg.sv
// Shared types and helpers for the buffered writeback stage: instruction
// class decode, load funct3 encodings, FSM states and the queue entry tag.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_JMP  = 2'd1,
        WB_LOAD = 2'd2,
        WB_NOWR = 2'd3
    } wb_class_e;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Outstanding-response counter; flushes during DRAIN can stack up loads.
    localparam int DRAIN_W = 8;

    // Control part of a queue entry; rd and alu_out live in parallel arrays
    // because their widths are module parameters.
    typedef struct packed {
        wb_class_e  cls;
        logic [2:0] funct3;
    } wb_meta_t;

    function automatic wb_class_e wb_decode(input logic [5:0] opcode);
        wb_class_e cls;
        if (!opcode[5]) begin
            cls = WB_ALU;
        end else begin
            case (opcode[4:3])
                2'b11:   cls = WB_JMP;
                2'b00:   cls = WB_LOAD;
                default: cls = WB_NOWR;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Combinational sub-word load extraction and sign/zero extension.
// WB_MISALIGN_TRAP_EN adds a misalign flag for unaligned LH/LHU/LW.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
`ifdef WB_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr, 3'b000} +: 8];
        half_sel = word[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0])
            misalign = 1'b1;
        if (funct3 == F3_LW && addr != 2'b00)
            misalign = 1'b1;
    end
`endif

endmodule

// File: rtl/pipeline_wb_q.sv
// Buffered writeback stage: in-order DEPTH-entry queue, load-response wait,
// flush with response drain, registered RF write port. Option: WB_MISALIGN_TRAP_EN.
module pipeline_wb_q
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [5:0]         opcode_i,
    input  logic [2:0]         funct3_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]    alu_out_i,
    input  logic               flush_i,
    input  logic               dmem_rvalid_i,
    input  logic [XLEN-1:0]    dmem_rdata_i,
    output logic               dmem_rready_o,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]    reg_data_o,
    output logic               busy_o,
`ifdef WB_MISALIGN_TRAP_EN
    output logic               misalign_o,
`endif
    output wb_state_e          state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a beat transfers on the rising edge where in_valid_i and
    // in_ready_o are both high; a load response transfers where
    // dmem_rvalid_i and dmem_rready_o are both high. Neither side may make
    // valid depend on ready.

    wb_meta_t           meta_q [DEPTH];
    logic [RADDR_W-1:0] rd_q   [DEPTH];
    logic [XLEN-1:0]    data_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    wb_state_e          state_q, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt, drain_base, flush_loads;
    logic               drain_dec;

    wb_meta_t           head_meta;
    logic [RADDR_W-1:0] head_rd;
    logic [XLEN-1:0]    head_data;
    logic               head_is_load;
    logic               push, retire, wr_en;
    logic [XLEN-1:0]    ext_result, wdata;
`ifdef WB_MISALIGN_TRAP_EN
    logic               ext_misalign, trap;
`endif

    assign head_meta    = meta_q[rd_ptr];
    assign head_rd      = rd_q[rd_ptr];
    assign head_data    = data_q[rd_ptr];
    assign head_is_load = (count != '0) && (head_meta.cls == WB_LOAD);

    assign in_ready_o    = (state_q == WB_RUN) && (count != CNT_W'(DEPTH));
    assign dmem_rready_o = (state_q == WB_DRAIN) || head_is_load;
    assign busy_o        = (count != '0) || (state_q == WB_DRAIN);
    assign state_o       = state_q;

    assign push   = in_valid_i && in_ready_o && !flush_i;
    // A head never retires in DRAIN because the queue is empty there.
    assign retire = (state_q == WB_RUN) && (count != '0) &&
                    (!head_is_load || dmem_rvalid_i);

    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .word     (dmem_rdata_i),
        .addr     (head_data[1:0]),
        .funct3   (head_meta.funct3),
`ifdef WB_MISALIGN_TRAP_EN
        .misalign (ext_misalign),
`endif
        .result   (ext_result)
    );

    // Loads still in the queue that do not retire on this edge; a flush
    // turns each of them into one response to discard.
    always_comb begin
        flush_loads = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < int'(count)) && !(k == 0 && retire) &&
                (meta_q[rd_ptr + PTR_W'(k)].cls == WB_LOAD))
                flush_loads = flush_loads + DRAIN_W'(1);
        end
    end

    always_comb begin
        drain_dec  = (state_q == WB_DRAIN) && dmem_rvalid_i && (drain_cnt != '0);
        drain_base = drain_cnt - DRAIN_W'(drain_dec);
        drain_nxt  = drain_base;
        state_nxt  = state_q;
        if (flush_i) begin
            drain_nxt = drain_base + flush_loads;
            state_nxt = (drain_nxt != '0) ? WB_DRAIN : WB_RUN;
        end else if (state_q == WB_DRAIN && drain_base == '0) begin
            state_nxt = WB_RUN;
        end
    end

    always_comb begin
        wr_en = retire && (head_meta.cls != WB_NOWR) && (head_rd != '0);
`ifdef WB_MISALIGN_TRAP_EN
        trap = retire && head_is_load && ext_misalign;
        if (trap)
            wr_en = 1'b0;
`endif
        wdata = head_is_load ? ext_result : head_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= WB_RUN;
            drain_cnt <= '0;
        end else begin
            state_q   <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (retire)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(retire);
        end
    end

    // Entry storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            meta_q[wr_ptr] <= '{cls: wb_decode(opcode_i), funct3: funct3_i};
            rd_q[wr_ptr]   <= rd_i;
            data_q[wr_ptr] <= alu_out_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_we_o   <= 1'b0;
            rd_o       <= '0;
            reg_data_o <= '0;
        end else begin
            reg_we_o <= wr_en;
            if (wr_en) begin
                rd_o       <= head_rd;
                reg_data_o <= wdata;
            end
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            misalign_o <= 1'b0;
        else
            misalign_o <= trap;
    end
`endif

endmodule

// File: tb/tb_pipeline_wb_q.sv
// Directed bench for pipeline_wb_q: inputs driven and outputs sampled on the
// falling clock edge. Honours WB_MISALIGN_TRAP_EN when defined.
module tb_pipeline_wb_q;
    import wb_pkg::*;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LOAD = 6'b100000;
    localparam logic [5:0] OP_JMP  = 6'b111000;
    localparam logic [5:0] OP_ST   = 6'b101000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [5:0]         opcode = '0;
    logic [2:0]         funct3 = '0;
    logic [RADDR_W-1:0] rd = '0;
    logic [XLEN-1:0]    alu_out = '0;
    logic               flush = 1'b0;
    logic               dmem_rvalid = 1'b0;
    logic [XLEN-1:0]    dmem_rdata = '0;
    logic               dmem_rready;
    logic               reg_we;
    logic [RADDR_W-1:0] rd_out;
    logic [XLEN-1:0]    reg_data;
    logic               busy;
    wb_state_e          state;
`ifdef WB_MISALIGN_TRAP_EN
    logic               misalign;
`endif

    int total = 0;
    int bad = 0;
    int proto_err = 0;
    logic [XLEN-1:0] exp_q[$];

    pipeline_wb_q #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .rd_i          (rd),
        .alu_out_i     (alu_out),
        .flush_i       (flush),
        .dmem_rvalid_i (dmem_rvalid),
        .dmem_rdata_i  (dmem_rdata),
        .dmem_rready_o (dmem_rready),
        .reg_we_o      (reg_we),
        .rd_o          (rd_out),
        .reg_data_o    (reg_data),
        .busy_o        (busy),
`ifdef WB_MISALIGN_TRAP_EN
        .misalign_o    (misalign),
`endif
        .state_o       (state)
    );

    always #5 clk = ~clk;

    // A response offered while the stage is not ready is a protocol error.
    always @(posedge clk) begin
        if (rst_n && dmem_rvalid && !dmem_rready)
            proto_err = proto_err + 1;
    end

    task automatic drive_beat(input logic [5:0] op, input logic [2:0] f3,
                              input logic [RADDR_W-1:0] r, input logic [XLEN-1:0] a);
        in_valid = 1'b1;
        opcode   = op;
        funct3   = f3;
        rd       = r;
        alu_out  = a;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (reg_we !== 1'b0) begin $display("FAIL rst_we got=%b exp=0", reg_we); bad++; end
        total++; if (rd_out !== '0) begin $display("FAIL rst_rd got=%0d exp=0", rd_out); bad++; end
        total++; if (reg_data !== '0) begin $display("FAIL rst_data got=%h exp=0", reg_data); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", busy); bad++; end
        total++; if (state !== WB_RUN) begin $display("FAIL rst_state got=%0d exp=0", state); bad++; end
        rst_n = 1'b1;
        // two stalled loads queued, then reset mid-operation
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd1, 32'h100);
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd2, 32'h104);
        @(negedge clk); idle_in();
        total++; if (in_ready !== 1'b0) begin $display("FAIL pre_rst_full got=%b exp=0", in_ready); bad++; end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (reg_we !== 1'b0) begin $display("FAIL mid_rst_we got=%b exp=0", reg_we); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL mid_rst_busy got=%b exp=0", busy); bad++; end
        total++; if (in_ready !== 1'b1) begin $display("FAIL mid_rst_ready got=%b exp=1", in_ready); bad++; end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk); drive_beat(OP_ALU, 3'b000, 5'd5, 32'h1234);
        @(negedge clk); idle_in();
        total++; if (reg_we !== 1'b0) begin $display("FAIL alu_early_we got=%b exp=0", reg_we); bad++; end
        total++; if (busy !== 1'b1) begin $display("FAIL alu_busy got=%b exp=1", busy); bad++; end
        @(negedge clk);
        total++; if (reg_we !== 1'b1) begin $display("FAIL alu_we got=%b exp=1", reg_we); bad++; end
        total++; if (rd_out !== 5'd5) begin $display("FAIL alu_rd got=%0d exp=5", rd_out); bad++; end
        total++; if (reg_data !== 32'h1234) begin $display("FAIL alu_data got=%h exp=1234", reg_data); bad++; end
        @(negedge clk);
        total++; if (reg_we !== 1'b0) begin $display("FAIL alu_pulse got=%b exp=0", reg_we); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL alu_idle got=%b exp=0", busy); bad++; end
        // rd=0 never writes and outputs hold
        drive_beat(OP_ALU, 3'b000, 5'd0, 32'h5555);
        @(negedge clk); idle_in();
        @(negedge clk);
        total++; if (reg_we !== 1'b0) begin $display("FAIL x0_we got=%b exp=0", reg_we); bad++; end
        total++; if (reg_data !== 32'h1234) begin $display("FAIL x0_hold got=%h exp=1234", reg_data); bad++; end
        // jump class writes, store class does not
        drive_beat(OP_JMP, 3'b000, 5'd6, 32'hBEEF);
        @(negedge clk); drive_beat(OP_ST, 3'b010, 5'd7, 32'h7777);
        @(negedge clk); idle_in();
        total++; if (reg_we !== 1'b1 || rd_out !== 5'd6 || reg_data !== 32'hBEEF) begin
            $display("FAIL jmp_wr got=%b/%0d/%h exp=1/6/beef", reg_we, rd_out, reg_data); bad++; end
        @(negedge clk);
        total++; if (reg_we !== 1'b0 || rd_out !== 5'd6) begin
            $display("FAIL store_nowr got=%b/%0d exp=0/6", reg_we, rd_out); bad++; end
    endtask

    task automatic test_load_ext();
        logic [2:0]      t_f3   [7] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LB, F3_LH, F3_LW};
        logic [XLEN-1:0] t_addr [7] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1000};
        logic [XLEN-1:0] t_word [7] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                                        32'h12345678, 32'h12345678, 32'h12345678};
        logic [XLEN-1:0] t_exp  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                                        32'h00000056, 32'h00005678, 32'h12345678};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); drive_beat(OP_LOAD, t_f3[i], 5'd10, t_addr[i]);
            @(negedge clk); idle_in();
            total++; if (dmem_rready !== 1'b1) begin $display("FAIL ld%0d_rready got=%b exp=1", i, dmem_rready); bad++; end
            dmem_rvalid = 1'b1;
            dmem_rdata  = t_word[i];
            @(negedge clk); dmem_rvalid = 1'b0;
            total++; if (reg_we !== 1'b1 || reg_data !== t_exp[i]) begin
                $display("FAIL ld%0d_data got=%b/%h exp=1/%h", i, reg_we, reg_data, t_exp[i]); bad++; end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd1, 32'h2000);
        @(negedge clk); drive_beat(OP_ALU, 3'b000, 5'd2, 32'hAA);
        total++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready1 got=%b exp=1", in_ready); bad++; end
        @(negedge clk); idle_in();
        total++; if (in_ready !== 1'b0) begin $display("FAIL b2b_full got=%b exp=0", in_ready); bad++; end
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h000000AA);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0 || reg_we !== 1'b0) begin
                $display("FAIL b2b_stall%0d got=%b/%b exp=0/0", c, in_ready, reg_we); bad++; end
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        @(negedge clk); dmem_rvalid = 1'b0;
        total++; if (reg_we !== 1'b1 || rd_out !== 5'd1 || reg_data !== exp_q[0]) begin
            $display("FAIL b2b_first got=%b/%0d/%h exp=1/1/%h", reg_we, rd_out, reg_data, exp_q[0]); bad++; end
        void'(exp_q.pop_front());
        total++; if (in_ready !== 1'b1) begin $display("FAIL b2b_ready2 got=%b exp=1", in_ready); bad++; end
        @(negedge clk);
        total++; if (reg_we !== 1'b1 || rd_out !== 5'd2 || reg_data !== exp_q[0]) begin
            $display("FAIL b2b_second got=%b/%0d/%h exp=1/2/%h", reg_we, rd_out, reg_data, exp_q[0]); bad++; end
        void'(exp_q.pop_front());
        @(negedge clk);
        total++; if (reg_we !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_done got=%b/%b exp=0/0", reg_we, busy); bad++; end
    endtask

    task automatic test_flush_drain();
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd3, 32'h10);
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd4, 32'h14);
        @(negedge clk); idle_in(); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        total++; if (state !== WB_DRAIN || in_ready !== 1'b0 || busy !== 1'b1 || dmem_rready !== 1'b1) begin
            $display("FAIL drain_enter got=%0d/%b/%b/%b exp=1/0/1/1", state, in_ready, busy, dmem_rready); bad++; end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD0BAD;
        @(negedge clk); dmem_rvalid = 1'b0;
        total++; if (reg_we !== 1'b0 || state !== WB_DRAIN) begin
            $display("FAIL drain_one got=%b/%0d exp=0/1", reg_we, state); bad++; end
        dmem_rvalid = 1'b1;
        @(negedge clk); dmem_rvalid = 1'b0;
        total++; if (reg_we !== 1'b0 || state !== WB_RUN || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL drain_exit got=%b/%0d/%b/%b exp=0/0/1/0", reg_we, state, in_ready, busy); bad++; end
    endtask

    task automatic test_flush_retire();
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd8, 32'h20);
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd9, 32'h24);
        @(negedge clk); idle_in();
        flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
        @(negedge clk); flush = 1'b0; dmem_rvalid = 1'b0;
        total++; if (reg_we !== 1'b1 || rd_out !== 5'd8 || reg_data !== 32'h11223344) begin
            $display("FAIL flush_head got=%b/%0d/%h exp=1/8/11223344", reg_we, rd_out, reg_data); bad++; end
        total++; if (state !== WB_DRAIN) begin $display("FAIL flush_head_state got=%0d exp=1", state); bad++; end
        dmem_rvalid = 1'b1;
        @(negedge clk); dmem_rvalid = 1'b0;
        total++; if (state !== WB_RUN || reg_we !== 1'b0) begin
            $display("FAIL flush_head_exit got=%0d/%b exp=0/0", state, reg_we); bad++; end
        // beat presented during a flush with nothing queued is dropped
        drive_beat(OP_ALU, 3'b000, 5'd12, 32'hCC); flush = 1'b1;
        @(negedge clk); idle_in(); flush = 1'b0;
        total++; if (busy !== 1'b0 || state !== WB_RUN) begin
            $display("FAIL flush_drop got=%b/%0d exp=0/0", busy, state); bad++; end
        @(negedge clk);
        total++; if (reg_we !== 1'b0) begin $display("FAIL flush_drop_we got=%b exp=0", reg_we); bad++; end
    endtask

    task automatic test_misalign();
        @(negedge clk); drive_beat(OP_LOAD, F3_LW, 5'd11, 32'h3002);
        @(negedge clk); idle_in();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk); dmem_rvalid = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
        total++; if (misalign !== 1'b1 || reg_we !== 1'b0) begin
            $display("FAIL mis_trap got=%b/%b exp=1/0", misalign, reg_we); bad++; end
        @(negedge clk);
        total++; if (misalign !== 1'b0) begin $display("FAIL mis_pulse got=%b exp=0", misalign); bad++; end
`else
        total++; if (reg_we !== 1'b1 || rd_out !== 5'd11 || reg_data !== 32'h12345678) begin
            $display("FAIL mis_word got=%b/%0d/%h exp=1/11/12345678", reg_we, rd_out, reg_data); bad++; end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_back_to_back();
        test_flush_drain();
        test_flush_retire();
        test_misalign();
        @(negedge clk);
        total++; if (proto_err !== 0) begin $display("FAIL protocol got=%0d exp=0", proto_err); bad++; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
